// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with clock-enable and frame-aligned run/stop.
// Optional macro VGA_TIMING_FRAME_CNT_EN adds a 16-bit frame counter output (frame_cnt).
module vga_timing_gen #(
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 40,
    parameter int H_SYNC   = 128,
    parameter int H_BP     = 88,
    parameter int V_ACTIVE = 600,
    parameter int V_FP     = 1,
    parameter int V_SYNC   = 4,
    parameter int V_BP     = 23,
    parameter bit H_POL    = 1'b1,
    parameter bit V_POL    = 1'b1,
    parameter int CW       = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ce,
    input  logic          en,
    output logic          hs,
    output logic          vs,
    output logic          de,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          line_start,
    output logic          frame_start,
    output logic          vblank,
    output logic          running,
`ifdef VGA_TIMING_FRAME_CNT_EN
    output logic [15:0]   frame_cnt,
`endif
    output logic [1:0]    o_dbg_state
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] H_SS   = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] H_SE   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] V_SS   = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] V_SE   = CW'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_h;
    logic [CW-1:0] r_v;

    logic          w_last;
    logic          w_go;
    logic [CW-1:0] w_nh;
    logic [CW-1:0] w_nv;
    logic          w_de;
    logic          w_hsync;
    logic          w_vsync;

    assign o_dbg_state = r_state;

    // r_h/r_v hold the pixel currently presented; w_nh/w_nv is the pixel the next ce edge emits.
    always_comb begin
        w_last = (r_h == H_LAST) && (r_v == V_LAST);
        w_go   = 1'b0;
        w_nh   = '0;
        w_nv   = '0;
        if (r_state == S_IDLE) begin
            w_go = en;
        end else begin
            w_go = en || !w_last;
            if (r_h == H_LAST) begin
                w_nv = (r_v == V_LAST) ? '0 : r_v + 1'b1;
            end else begin
                w_nh = r_h + 1'b1;
                w_nv = r_v;
            end
        end
        w_de    = (w_nh < H_ACT) && (w_nv < V_ACT);
        w_hsync = (w_nh >= H_SS) && (w_nh < H_SE);
        w_vsync = (w_nv >= V_SS) && (w_nv < V_SE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_h         <= '0;
            r_v         <= '0;
            hs          <= ~H_POL;
            vs          <= ~V_POL;
            de          <= 1'b0;
            x           <= '0;
            y           <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            vblank      <= 1'b0;
            running     <= 1'b0;
`ifdef VGA_TIMING_FRAME_CNT_EN
            frame_cnt   <= '0;
`endif
        end else if (ce) begin
            if (w_go) begin
                r_state     <= en ? S_RUN : S_DRAIN;
                r_h         <= w_nh;
                r_v         <= w_nv;
                hs          <= w_hsync ? H_POL : ~H_POL;
                vs          <= w_vsync ? V_POL : ~V_POL;
                de          <= w_de;
                x           <= w_de ? w_nh : '0;
                y           <= w_de ? w_nv : '0;
                line_start  <= (w_nh == '0);
                frame_start <= (w_nh == '0) && (w_nv == '0);
                vblank      <= (w_nv >= V_ACT);
                running     <= 1'b1;
`ifdef VGA_TIMING_FRAME_CNT_EN
                if ((w_nh == '0) && (w_nv == '0)) frame_cnt <= frame_cnt + 16'd1;
`endif
            end else begin
                // Either idle with no request, or the last pixel of a draining frame has been shown.
                r_state     <= S_IDLE;
                r_h         <= '0;
                r_v         <= '0;
                hs          <= ~H_POL;
                vs          <= ~V_POL;
                de          <= 1'b0;
                x           <= '0;
                y           <= '0;
                line_start  <= 1'b0;
                frame_start <= 1'b0;
                vblank      <= 1'b0;
                running     <= 1'b0;
            end
        end
    end

endmodule
